// File: rtl/auth_pwr_seq.sv
// Rider authorization and power sequencer: decodes G/S command bytes, filters rider_off, drives pwr_up/ss_clr.
// Latency: byte consumed in cycle N -> state_o/pwr_up/ss_clr/clr_rx_rdy updated in cycle N+1.
// Backpressure: none; each flagged byte is acked with a one-cycle clr_rx_rdy and never re-consumed during the ack.
module auth_pwr_seq #(
  parameter logic [7:0]  CMD_GO   = 8'h47,
  parameter logic [7:0]  CMD_STOP = 8'h53,
  parameter logic [15:0] OFF_FILT = 16'd50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  output logic       clr_rx_rdy,
  input  logic       rider_off,
  output logic       pwr_up,
  output logic       ss_clr,
  output logic [1:0] state_o,
  output logic [7:0] bad_cmd_cnt
);

  typedef enum logic [1:0] {
    OFF  = 2'b00,
    PWR1 = 2'b01,
    PWR2 = 2'b10
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        ss_clr_nxt;

  logic        rider_off_s1;
  logic        rider_off_s2;
  logic [15:0] off_cnt;
  logic [15:0] off_cnt_nxt;
  logic        off_q;

  logic        consumed;
  logic        go;
  logic        stop;
  logic        bad;

  // A byte is taken only when it was not already acked last cycle.
  assign consumed = rx_rdy && !clr_rx_rdy;
  assign go       = consumed && (rx_data == CMD_GO);
  assign stop     = consumed && (rx_data == CMD_STOP);
  assign bad      = consumed && !go && !stop;

  // Two-flop synchronizer for the raw rider-absent flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rider_off_s1 <= 1'b0;
      rider_off_s2 <= 1'b0;
    end else begin
      rider_off_s1 <= rider_off;
      rider_off_s2 <= rider_off_s1;
    end
  end

  // Next filter count: saturating run length of the synced flag.
  always_comb begin
    off_cnt_nxt = off_cnt;
    if (!rider_off_s2) begin
      off_cnt_nxt = 16'd0;
    end else if (off_cnt != OFF_FILT) begin
      off_cnt_nxt = off_cnt + 16'd1;
    end
  end

  // Filter registers; off_q tracks the count so it is high exactly when the count is saturated.
  always_ff @(posedge clk) begin
    if (rst) begin
      off_cnt <= 16'd0;
      off_q   <= 1'b0;
    end else begin
      off_cnt <= off_cnt_nxt;
      off_q   <= (off_cnt_nxt == OFF_FILT);
    end
  end

  // Byte acknowledge pulse and saturating rejected-byte counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_rx_rdy  <= 1'b0;
      bad_cmd_cnt <= 8'd0;
    end else begin
      clr_rx_rdy <= consumed;
      if (bad && (bad_cmd_cnt != 8'hFF)) begin
        bad_cmd_cnt <= bad_cmd_cnt + 8'd1;
      end
    end
  end

  // Next-state decode; stop is judged against the registered off_q of this cycle.
  always_comb begin
    state_nxt  = state;
    ss_clr_nxt = 1'b0;
    case (state)
      OFF: begin
        if (go) begin
          state_nxt  = PWR1;
          ss_clr_nxt = 1'b1;
        end
      end
      PWR1: begin
        if (stop) begin
          state_nxt = off_q ? OFF : PWR2;
        end
      end
      PWR2: begin
        if (off_q) begin
          state_nxt = OFF;
        end else if (go) begin
          state_nxt = PWR1;
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  // State register with registered power enable and soft-start clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= OFF;
      pwr_up <= 1'b0;
      ss_clr <= 1'b0;
    end else begin
      state  <= state_nxt;
      pwr_up <= (state_nxt != OFF);
      ss_clr <= ss_clr_nxt;
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_auth_pwr_seq.sv
// Bench for auth_pwr_seq: cycle-level reference model compared every cycle plus directed literal checks.
// Uses a short rider filter so the qualification scenarios stay brief.
// Inputs are driven on the falling edge; outputs are compared on the falling edge.
module tb_auth_pwr_seq;

  localparam logic [15:0] F = 16'd20;

  logic       clk;
  logic       rst;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       clr_rx_rdy;
  logic       rider_off;
  logic       pwr_up;
  logic       ss_clr;
  logic [1:0] state_o;
  logic [7:0] bad_cmd_cnt;

  auth_pwr_seq #(
    .CMD_GO  (8'h47),
    .CMD_STOP(8'h53),
    .OFF_FILT(F)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .rider_off  (rider_off),
    .pwr_up     (pwr_up),
    .ss_clr     (ss_clr),
    .state_o    (state_o),
    .bad_cmd_cnt(bad_cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: protocol-level view of consumption, power states and rider qualification.
  int  m_state;     // 0 off, 1 running, 2 stop pending
  bit  m_ss;
  bit  m_ack;
  int  m_bad;
  bit  m_qual;
  int  run_len;     // consecutive rider_off=1 samples that have cleared the synchronizer
  bit  samp_q[$];   // samples still in flight through the two-flop synchronizer
  bit  m_valid = 1'b0;

  always @(posedge clk) begin
    bit consumed, go, stop, qual_prev, delayed;
    int nxt;
    if (rst) begin
      m_state = 0; m_ss = 0; m_ack = 0; m_bad = 0; m_qual = 0; run_len = 0;
      samp_q.delete();
      samp_q.push_back(1'b0);
      samp_q.push_back(1'b0);
      m_valid = 1'b1;
    end else if (m_valid) begin
      consumed  = rx_rdy && !m_ack;
      go        = consumed && rx_data == 8'h47;
      stop      = consumed && rx_data == 8'h53;
      qual_prev = m_qual;
      nxt = m_state;
      if (m_state == 0 && go) nxt = 1;
      else if (m_state == 1 && stop) nxt = qual_prev ? 0 : 2;
      else if (m_state == 2 && qual_prev) nxt = 0;
      else if (m_state == 2 && go) nxt = 1;
      m_ss    = (m_state == 0) && go;
      m_state = nxt;
      m_ack   = consumed;
      if (consumed && !go && !stop && m_bad < 255) m_bad++;
      samp_q.push_back(rider_off);
      delayed = samp_q.pop_front();
      run_len = delayed ? run_len + 1 : 0;
      m_qual  = (run_len >= int'(F));
    end
  end

  int ack_cnt = 0;
  int ss_cnt  = 0;

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (m_valid && !rst) begin
      if (state_o !== 2'(m_state) || pwr_up !== (m_state != 0) || ss_clr !== m_ss ||
          clr_rx_rdy !== m_ack || bad_cmd_cnt !== 8'(m_bad)) begin
        n_chk++;
        $display("FAIL cycle_model t=%0t: got st=%0d pwr=%0b ss=%0b ack=%0b bad=%0d expected st=%0d pwr=%0b ss=%0b ack=%0b bad=%0d",
                 $time, state_o, pwr_up, ss_clr, clr_rx_rdy, bad_cmd_cnt,
                 m_state, m_state != 0, m_ss, m_ack, m_bad);
      end else begin
        n_chk++;
        n_pass++;
      end
      if (clr_rx_rdy) ack_cnt++;
      if (ss_clr) ss_cnt++;
    end
  end

  logic [1:0] st_after;
  logic       ss_after;
  logic       pwr_after;

  // Holds rx_rdy through the ack cycle, then drops it, as the UART would.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(negedge clk);
    st_after  = state_o;
    ss_after  = ss_clr;
    pwr_after = pwr_up;
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int a0;
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rider_off = 1'b0;
    tick(3);
    rst = 1'b0;

    // 1: idle after reset
    tick(100);
    chk("idle_state", state_o, 2'b00);
    chk("idle_pwr", pwr_up, 1'b0);
    chk("idle_ack", clr_rx_rdy, 1'b0);
    chk("idle_bad", bad_cmd_cnt, 8'd0);

    // 2: go from OFF, then a second go
    a0 = ack_cnt;
    send_byte(8'h47);
    chk("go_state", st_after, 2'b01);
    chk("go_pwr", pwr_after, 1'b1);
    chk("go_ssclr", ss_after, 1'b1);
    chk("go_one_ack", ack_cnt - a0, 1);
    send_byte(8'h47);
    chk("go2_state", st_after, 2'b01);
    chk("go2_no_ssclr", ss_cnt, 1);

    // 3: stop with rider on, then filtered rider_off with a late glitch
    send_byte(8'h53);
    chk("stop_pwr2_state", st_after, 2'b10);
    chk("stop_pwr2_pwr", pwr_after, 1'b1);
    rider_off = 1'b1;
    tick(int'(F) - 1);
    rider_off = 1'b0;
    tick(1);
    rider_off = 1'b1;
    tick(int'(F) + 2);
    chk("glitch_restart_state", state_o, 2'b10);
    tick(1);
    chk("filter_off_state", state_o, 2'b00);
    chk("filter_off_pwr", pwr_up, 1'b0);

    // 4: rider already qualified off -> stop goes straight to OFF
    send_byte(8'h47);
    chk("reauth_ssclr", ss_after, 1'b1);
    send_byte(8'h53);
    chk("direct_off_state", st_after, 2'b00);
    chk("direct_off_pwr", pwr_after, 1'b0);

    // 5: rider back on, power up, flood with bad bytes
    rider_off = 1'b0;
    send_byte(8'h47);
    a0 = ack_cnt;
    for (int i = 0; i < 300; i++) send_byte(8'h00);
    chk("bad_saturated", bad_cmd_cnt, 8'hFF);
    chk("bad_state_kept", state_o, 2'b01);
    chk("bad_ack_once_each", ack_cnt - a0, 300);

    // 6: reset mid-sequence from PWR2
    send_byte(8'h53);
    chk("pre_rst_state", st_after, 2'b10);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_state", state_o, 2'b00);
    chk("rst_pwr", pwr_up, 1'b0);
    chk("rst_bad", bad_cmd_cnt, 8'd0);
    send_byte(8'h47);
    chk("post_rst_ssclr", ss_after, 1'b1);
    chk("post_rst_state", st_after, 2'b01);
    tick(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
